// File: rtl/flac_pkg.sv
// Shared widths, FSM encoding and output-FIFO entry layout for the residual stage.
package flac_pkg;

    localparam int unsigned MSB_W   = 16;
    localparam int unsigned LSB_W   = 16;
    localparam int unsigned K_W     = 4;
    localparam int unsigned OUT_W   = 32;
    localparam int unsigned BS_W    = 16;
    localparam int unsigned PIDX_W  = 16;
    localparam int unsigned ENTRY_W = OUT_W + 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef struct packed {
        logic [OUT_W-1:0] residual;
        logic             part_end;
        logic             block_end;
    } fifo_entry_t;

    // Zig-zag unfold: even u -> u/2, odd u -> -(u+1)/2.
    function automatic logic [OUT_W-1:0] zigzag_unfold(input logic [OUT_W-1:0] u);
        return (u >> 1) ^ {OUT_W{u[0]}};
    endfunction

endpackage

// File: rtl/rice_res_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO without a pop is dropped.
module rice_res_fifo
    import flac_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_wr_data,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_head_c,
    output logic               o_empty_c,
    output logic               o_drop_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               w_full;
    logic               w_pop;
    logic               w_wr;

    assign w_full    = (r_count == CW'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign w_pop     = i_pop & ~o_empty_c;
    assign w_wr      = i_push & (~w_full | w_pop);
    assign o_drop_c  = i_push & w_full & ~w_pop;
    assign o_head_c  = o_empty_c ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset since the head is masked when empty.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rice_residual_unfold.sv
// Rice codeword -> signed residual, with partition/block tagging and an output FIFO.
module rice_residual_unfold
    import flac_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [BS_W-1:0]  iBlockSize,
    input  logic [3:0]       iPartOrder,
    input  logic [5:0]       iPredOrder,
    input  logic [K_W-1:0]   iRiceParam,
    input  logic [MSB_W-1:0] iMSB,
    input  logic [LSB_W-1:0] iLSB,
    input  logic             iDone,
    output logic [OUT_W-1:0] oResidual,
    output logic             oValid,
    input  logic             iReady,
    output logic             oPartEnd,
    output logic             oBlockEnd,
    output logic             oParamReq,
    output logic             oOverflow,
    output logic             oBusy
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [BS_W-1:0]   r_part_size;
    logic [BS_W-1:0]   r_remaining;
    logic [PIDX_W-1:0] r_part_idx;
    logic [PIDX_W-1:0] r_last_part;
    logic              r_req_pend;
    logic              r_param_req;
    logic              r_overflow;

    logic              r_s1_valid;
    logic [OUT_W-1:0]  r_s1_u;
    logic              r_s1_pe;
    logic              r_s1_be;
    logic              r_s2_valid;
    fifo_entry_t       r_s2_entry;

    logic              w_start;
    logic              w_accept;
    logic [BS_W-1:0]   w_rem_dec;
    logic              w_part_end;
    logic              w_block_end;
    logic [BS_W-1:0]   w_cfg_part_size;
    logic [BS_W-1:0]   w_cfg_rem;
    logic [PIDX_W-1:0] w_cfg_last;
    logic [OUT_W-1:0]  w_mask;
    logic [OUT_W-1:0]  w_u;
    fifo_entry_t       w_head;
    logic              w_fifo_empty;
    logic              w_fifo_drop;
    logic              w_pop;

    assign w_start         = (r_state == ST_IDLE) & iStart;
    assign w_accept        = (r_state == ST_RUN) & iDone;
    assign w_rem_dec       = r_remaining - BS_W'(1);
    assign w_part_end      = w_accept & (w_rem_dec == '0);
    assign w_block_end     = w_part_end & (r_part_idx == r_last_part);
    assign w_cfg_part_size = iBlockSize >> iPartOrder;
    assign w_cfg_rem       = w_cfg_part_size - BS_W'(iPredOrder);
    assign w_cfg_last      = (PIDX_W'(1) << iPartOrder) - PIDX_W'(1);
    assign w_mask          = (OUT_W'(1) << iRiceParam) - OUT_W'(1);
    assign w_u             = (OUT_W'(iMSB) << iRiceParam) | (OUT_W'(iLSB) & w_mask);
    assign w_pop           = oValid & iReady;

    // State register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: drain waits for both pipeline stages and the FIFO to empty.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (iStart) w_state_next = ST_RUN;
            ST_RUN:   if (w_block_end) w_state_next = ST_DRAIN;
            ST_DRAIN: if (~r_s1_valid & ~r_s2_valid & w_fifo_empty) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Block configuration, partition counters and the delayed parameter request.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_part_size <= '0;
            r_remaining <= '0;
            r_part_idx  <= '0;
            r_last_part <= '0;
            r_req_pend  <= 1'b0;
            r_param_req <= 1'b0;
        end else begin
            r_req_pend  <= 1'b0;
            r_param_req <= r_req_pend;
            if (w_start) begin
                r_part_size <= w_cfg_part_size;
                r_last_part <= w_cfg_last;
                if (w_cfg_rem == '0) begin
                    // Partition 0 is all warm-up: move straight on to partition 1.
                    r_remaining <= w_cfg_part_size;
                    r_part_idx  <= PIDX_W'(1);
                    r_req_pend  <= 1'b1;
                end else begin
                    r_remaining <= w_cfg_rem;
                    r_part_idx  <= '0;
                end
            end else if (w_accept) begin
                if (w_part_end & ~w_block_end) begin
                    r_remaining <= r_part_size;
                    r_part_idx  <= r_part_idx + PIDX_W'(1);
                    r_req_pend  <= 1'b1;
                end else begin
                    r_remaining <= w_rem_dec;
                end
            end
        end
    end

    // Two-stage datapath: merge quotient/remainder, then zig-zag unfold.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_s1_valid <= 1'b0;
            r_s1_u     <= '0;
            r_s1_pe    <= 1'b0;
            r_s1_be    <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_entry <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_u  <= w_u;
                r_s1_pe <= w_part_end;
                r_s1_be <= w_block_end;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_entry.residual  <= zigzag_unfold(r_s1_u);
                r_s2_entry.part_end  <= r_s1_pe;
                r_s2_entry.block_end <= r_s1_be;
            end
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_overflow <= 1'b0;
        end else if (w_fifo_drop) begin
            r_overflow <= 1'b1;
        end
    end

    rice_res_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (iClk),
        .i_rst     (iRst),
        .i_push    (r_s2_valid),
        .i_wr_data (r_s2_entry),
        .i_pop     (w_pop),
        .o_head_c  (w_head),
        .o_empty_c (w_fifo_empty),
        .o_drop_c  (w_fifo_drop)
    );

    assign oResidual = w_head.residual;
    assign oPartEnd  = w_head.part_end;
    assign oBlockEnd = w_head.block_end;
    assign oValid    = ~w_fifo_empty;
    assign oParamReq = r_param_req;
    assign oOverflow = r_overflow;
    assign oBusy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rice_residual_unfold.sv
// Randomized bench for rice_residual_unfold against an arithmetic reference model.
module tb_rice_residual_unfold;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iStart;
    logic [15:0] iBlockSize;
    logic [3:0]  iPartOrder;
    logic [5:0]  iPredOrder;
    logic [3:0]  iRiceParam;
    logic [15:0] iMSB;
    logic [15:0] iLSB;
    logic        iDone;
    logic [31:0] oResidual;
    logic        oValid;
    logic        iReady;
    logic        oPartEnd;
    logic        oBlockEnd;
    logic        oParamReq;
    logic        oOverflow;
    logic        oBusy;

    rice_residual_unfold dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iStart     (iStart),
        .iBlockSize (iBlockSize),
        .iPartOrder (iPartOrder),
        .iPredOrder (iPredOrder),
        .iRiceParam (iRiceParam),
        .iMSB       (iMSB),
        .iLSB       (iLSB),
        .iDone      (iDone),
        .oResidual  (oResidual),
        .oValid     (oValid),
        .iReady     (iReady),
        .oPartEnd   (oPartEnd),
        .oBlockEnd  (oBlockEnd),
        .oParamReq  (oParamReq),
        .oOverflow  (oOverflow),
        .oBusy      (oBusy)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        longint res;
        bit     pe;
        bit     be;
    } exp_t;

    exp_t exp_q[$];
    bit   req_exp[int];
    bit   m_pe[int];
    int   m_total;
    int   m_idx;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
    endtask

    task automatic next_cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic rand_cyc();
        iReady = ($urandom_range(0, 3) != 0);
        next_cyc();
    endtask

    // Scoreboard: pops and the parameter-request strobe, sampled on the falling edge.
    always @(negedge iClk) begin
        exp_t e;
        if (!iRst) begin
            chk("param_req", longint'(oParamReq), longint'(req_exp.exists(cyc)));
            if (oValid && iReady) begin
                chk("pop_has_expect", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("residual", longint'($signed(oResidual)), e.res);
                    chk("part_end", longint'(oPartEnd), longint'(e.pe));
                    chk("block_end", longint'(oBlockEnd), longint'(e.be));
                end
            end
        end
    end

    // Reference: list where each partition's coded residuals end.
    task automatic start_block(input int bs, input int po, input int pred);
        int psize;
        int pos;
        int cnt;
        bit req_start;
        psize     = bs >> po;
        pos       = 0;
        req_start = 0;
        m_pe.delete();
        for (int p = 0; p < (1 << po); p++) begin
            cnt = psize - ((p == 0) ? pred : 0);
            if (cnt == 0) req_start = 1;
            else begin
                pos += cnt;
                m_pe[pos - 1] = 1'b1;
            end
        end
        m_total = pos;
        m_idx   = 0;
        if (req_start) req_exp[cyc + 2] = 1'b1;
        iBlockSize = 16'(bs);
        iPartOrder = 4'(po);
        iPredOrder = 6'(pred);
        iStart     = 1'b1;
        next_cyc();
        iStart     = 1'b0;
    endtask

    task automatic strobe(input int unsigned msb, input int unsigned lsb,
                          input int unsigned k, input bit keep);
        longint u;
        longint res;
        bit     pe;
        bit     be;
        u   = (longint'(msb) << k) | (longint'(lsb) & ((longint'(1) << k) - 1));
        u   = u & 64'hFFFF_FFFF;
        res = (u % 2 == 1) ? -(u / 2) - 1 : u / 2;
        pe  = m_pe.exists(m_idx);
        be  = (m_idx == m_total - 1);
        if (keep) exp_q.push_back('{res, pe, be});
        if (pe && !be) req_exp[cyc + 2] = 1'b1;
        m_idx++;
        iMSB       = 16'(msb);
        iLSB       = 16'(lsb);
        iRiceParam = 4'(k);
        iDone      = 1'b1;
        next_cyc();
        iDone      = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        iReady = 1'b1;
        while ((oBusy || exp_q.size() != 0) && n < 200) begin
            next_cyc();
            n++;
        end
        chk({tag, "_idle_in_time"}, longint'(n < 200), 1);
        chk({tag, "_busy_low"}, longint'(oBusy), 0);
        chk({tag, "_valid_low"}, longint'(oValid), 0);
    endtask

    task automatic do_reset(input string tag);
        iRst   = 1'b1;
        iStart = 1'b0;
        iDone  = 1'b0;
        exp_q.delete();
        req_exp.delete();
        next_cyc();
        next_cyc();
        chk({tag, "_valid"}, longint'(oValid), 0);
        chk({tag, "_busy"}, longint'(oBusy), 0);
        chk({tag, "_overflow"}, longint'(oOverflow), 0);
        chk({tag, "_param_req"}, longint'(oParamReq), 0);
        chk({tag, "_residual"}, longint'(oResidual), 0);
        iRst = 1'b0;
    endtask

    task automatic random_block();
        int po;
        int psize;
        int bs;
        int pred;
        po    = $urandom_range(0, 2);
        psize = $urandom_range(1, 5);
        bs    = (psize << po) + $urandom_range(0, (1 << po) - 1);
        pred  = (po == 0) ? $urandom_range(0, psize - 1) : $urandom_range(0, psize);
        start_block(bs, po, pred);
        for (int n = 0; n < m_total; n++) begin
            repeat ($urandom_range(0, 2)) rand_cyc();
            for (int g = 0; g < 100 && exp_q.size() >= 4; g++) rand_cyc();
            iReady = ($urandom_range(0, 3) != 0);
            strobe($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 15), 1'b1);
        end
        wait_idle("rand");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iRst = 1'b1; iStart = 1'b0; iDone = 1'b0; iReady = 1'b1;
        iBlockSize = '0; iPartOrder = '0; iPredOrder = '0;
        iRiceParam = '0; iMSB = '0; iLSB = '0;
        do_reset("reset");

        // Basic unfold with first-result latency.
        start_block(6, 0, 2);
        strobe(5, 5, 3, 1'b1);
        @(negedge iClk); chk("lat_t0", longint'(oValid), 0);
        @(negedge iClk); chk("lat_t1", longint'(oValid), 0);
        @(negedge iClk); chk("lat_t2", longint'(oValid), 1);
        next_cyc();
        strobe(2, 6, 3, 1'b1);
        strobe(0, 2, 3, 1'b1);
        strobe(11, 1, 3, 1'b1);
        wait_idle("basic");

        // Two partitions, back-to-back strobes.
        start_block(8, 1, 2);
        for (int i = 0; i < 6; i++)
            strobe($urandom_range(0, 255), $urandom_range(0, 65535), $urandom_range(0, 15), 1'b1);
        wait_idle("parts");

        // k = 0 ignores the remainder.
        start_block(1, 0, 0);
        strobe(7, 16'hFFFF, 0, 1'b1);
        wait_idle("k0");

        // Empty first partition: request with no codeword.
        start_block(4, 1, 2);
        repeat (3) next_cyc();
        strobe($urandom_range(0, 255), $urandom_range(0, 65535), 3, 1'b1);
        strobe($urandom_range(0, 255), $urandom_range(0, 65535), 3, 1'b1);
        wait_idle("empty_p0");

        repeat (12) random_block();

        // Backpressure: fifth residual is dropped.
        start_block(16, 0, 0);
        iReady = 1'b0;
        for (int i = 0; i < 5; i++) strobe(0, i, 3, i < 4);
        repeat (4) next_cyc();
        chk("ovf_set", longint'(oOverflow), 1);
        chk("ovf_valid", longint'(oValid), 1);
        iReady = 1'b1;
        for (int g = 0; g < 50 && exp_q.size() != 0; g++) next_cyc();
        chk("ovf_drained", longint'(exp_q.size()), 0);
        chk("ovf_sticky", longint'(oOverflow), 1);
        do_reset("ovf_reset");

        // Reset after one of three residuals, then a fresh block.
        start_block(3, 0, 0);
        strobe($urandom_range(0, 255), $urandom_range(0, 65535), 5, 1'b1);
        repeat (4) next_cyc();
        do_reset("mid_reset");
        start_block(3, 0, 0);
        for (int i = 0; i < 3; i++)
            strobe($urandom_range(0, 255), $urandom_range(0, 65535), $urandom_range(0, 15), 1'b1);
        wait_idle("fresh");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
